// File: rtl/buscador_sar_pkg.sv
// Shared definitions for the successive-approximation search controller:
// comparator result codes and FSM state encodings.
package buscador_sar_pkg;

  localparam logic [2:0] CMP_MAYOR = 3'b100;
  localparam logic [2:0] CMP_MENOR = 3'b010;
  localparam logic [2:0] CMP_IGUAL = 3'b001;

  typedef enum logic [1:0] {
    REPOSO = 2'b00,
    PRUEBA = 2'b01,
    FIN    = 2'b10
  } estado_t;

endpackage

// File: rtl/buscador_sar_if.sv
// Handshake and comparator-side signals of the search controller.
// The master modport belongs to whoever drives inicio and owns the comparator.
interface buscador_sar_if #(
  parameter int bitsEntry = 4,
  parameter int bitsOut   = 3
);
  logic                 inicio;
  logic [bitsOut-1:0]   comparacion;
  logic [bitsEntry-1:0] prueba;
  logic [bitsEntry-1:0] resultado;
  logic                 ocupado;
  logic                 listo;
  logic                 error;

  modport master (
    output inicio, comparacion,
    input  prueba, resultado, ocupado, listo, error
  );

  modport slave (
    input  inicio, comparacion,
    output prueba, resultado, ocupado, listo, error
  );
endinterface

// File: rtl/buscador_sar.sv
// Successive-approximation search: walks a trial code MSB-first against an external
// magnitude comparator and reports the converged value (or an error on inconsistent results).
//
// state  | meaning
// REPOSO | idle, waiting for inicio
// PRUEBA | trial code on prueba, deciding one bit per cycle from comparacion
// FIN    | one-cycle listo pulse, then back to REPOSO
module buscador_sar
  import buscador_sar_pkg::*;
#(
  parameter int bitsEntry = 4,
  parameter int bitsOut   = 3
) (
  input  logic           clk,
  input  logic           rst,
  buscador_sar_if.slave  bus
);

  localparam int IW = $clog2(bitsEntry);
  localparam logic [IW-1:0]        IDX_TOP    = IW'(bitsEntry - 1);
  localparam logic [bitsEntry-1:0] TRIAL_INIT = {1'b1, {(bitsEntry-1){1'b0}}};

  estado_t              estado_q, estado_d;
  logic [bitsEntry-1:0] prueba_q, prueba_d;
  logic [bitsEntry-1:0] resultado_q, resultado_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 error_q, error_d;

  logic [IW-1:0]        idx_m1;
  logic [bitsEntry-1:0] trial_clr;
  logic [bitsEntry-1:0] trial_menor;
  logic [bitsEntry-1:0] trial_mayor;

  // Candidate next trials; idx_m1 is only consumed when idx_q != 0, so its wrap is harmless.
  always_comb begin
    idx_m1              = idx_q - IW'(1);
    trial_clr           = prueba_q;
    trial_clr[idx_q]    = 1'b0;
    trial_menor         = trial_clr;
    trial_menor[idx_m1] = 1'b1;
    trial_mayor         = prueba_q;
    trial_mayor[idx_m1] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q    <= REPOSO;
      prueba_q    <= '0;
      resultado_q <= '0;
      idx_q       <= IDX_TOP;
      error_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      prueba_q    <= prueba_d;
      resultado_q <= resultado_d;
      idx_q       <= idx_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    prueba_d    = prueba_q;
    resultado_d = resultado_q;
    idx_d       = idx_q;
    error_d     = error_q;
    case (estado_q)
      REPOSO: begin
        if (bus.inicio) begin
          prueba_d = TRIAL_INIT;
          idx_d    = IDX_TOP;
          error_d  = 1'b0;
          estado_d = PRUEBA;
        end
      end
      PRUEBA: begin
        case (bus.comparacion)
          CMP_IGUAL: begin
            resultado_d = prueba_q;
            estado_d    = FIN;
          end
          CMP_MENOR: begin
            if (idx_q == '0) begin
              prueba_d    = trial_clr;
              resultado_d = trial_clr;
              estado_d    = FIN;
            end else begin
              prueba_d = trial_menor;
              idx_d    = idx_m1;
            end
          end
          CMP_MAYOR: begin
            // A above the all-ones tail at the last bit means A moved during the search.
            if (idx_q == '0) begin
              error_d     = 1'b1;
              resultado_d = '0;
              estado_d    = FIN;
            end else begin
              prueba_d = trial_mayor;
              idx_d    = idx_m1;
            end
          end
          default: begin
            error_d     = 1'b1;
            resultado_d = '0;
            estado_d    = FIN;
          end
        endcase
      end
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  assign bus.prueba    = prueba_q;
  assign bus.resultado = resultado_q;
  assign bus.error     = error_q;
  assign bus.ocupado   = (estado_q == PRUEBA);
  assign bus.listo     = (estado_q == FIN);

endmodule

// File: tb/tb_buscador_sar.sv
// Bench for buscador_sar: ideal comparator on objetivo, binary-search reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_buscador_sar;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buscador_sar_if #(.bitsEntry(N), .bitsOut(3)) bus();
  buscador_sar #(.bitsEntry(N), .bitsOut(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [N-1:0] objetivo;
  logic         force_en;
  logic [2:0]   force_val;

  assign bus.comparacion = force_en ? force_val
                         : {objetivo > bus.prueba, objetivo < bus.prueba, objetivo == bus.prueba};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the whole trial list is derived arithmetically when a search starts.
  int m_q[$];
  bit m_busy, m_fin, m_err;
  int m_res, m_prueba;

  function automatic void build_trials(input int a);
    int lo, t;
    lo = 0;
    m_q.delete();
    for (int b = N - 1; b >= 0; b--) begin
      t = lo + (1 << b);
      m_q.push_back(t);
      if (t == a) break;
      if (t < a) lo = t;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_fin = 0; m_err = 0; m_res = 0; m_prueba = 0;
      m_q.delete();
    end else if (m_fin) begin
      m_fin = 0;
    end else if (m_busy) begin
      if (force_en) begin
        m_err = 1; m_res = 0; m_busy = 0; m_fin = 1;
      end else begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_res = int'(objetivo); m_prueba = int'(objetivo); m_busy = 0; m_fin = 1;
        end else begin
          m_prueba = m_q[0];
        end
      end
    end else if (bus.inicio) begin
      build_trials(int'(objetivo));
      m_prueba = m_q[0];
      m_err = 0;
      m_busy = 1;
    end
  end

  int obs_seq[$];

  always @(negedge clk) begin
    if (!rst) begin
      check("ocupado",   bus.ocupado,   m_busy);
      check("listo",     bus.listo,     m_fin);
      check("error",     bus.error,     m_err);
      check("prueba",    bus.prueba,    m_prueba);
      check("resultado", bus.resultado, m_res);
      if (bus.ocupado) obs_seq.push_back(int'(bus.prueba));
    end
  end

  task automatic wait_listo(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.listo) begin ok = 1; break; end
    end
    if (!ok) check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run(input int a, output int edges);
    bit ok;
    @(negedge clk); #1;
    obs_seq.delete();
    objetivo = N'(a);
    bus.inicio = 1'b1;
    @(posedge clk);
    edges = 1;
    #1 bus.inicio = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.listo) begin ok = 1; break; end
      @(posedge clk);
      edges++;
    end
    if (!ok) check("run_timeout", 0, 1);
  endtask

  // Expected trials packed as nibbles, first trial in the most significant used nibble.
  task automatic check_seq(input string nm, input int cnt, input logic [31:0] nib);
    check({nm, "_len"}, obs_seq.size(), cnt);
    for (int i = 0; i < cnt && i < obs_seq.size(); i++)
      check({nm, "_trial"}, obs_seq[i], (nib >> (4 * (cnt - 1 - i))) & 32'hF);
  endtask

  int edges;
  int listo_cnt;

  initial begin
    rst = 1'b1;
    bus.inicio = 1'b0;
    objetivo = '0;
    force_en = 1'b0;
    force_val = 3'b000;
    #2;
    check("rst_prueba",    bus.prueba,    0);
    check("rst_resultado", bus.resultado, 0);
    check("rst_ocupado",   bus.ocupado,   0);
    check("rst_listo",     bus.listo,     0);
    check("rst_error",     bus.error,     0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(5, edges);
    check("t1_edges", edges, 5);
    check_seq("t1", 4, 32'h8465);
    check("t1_res", bus.resultado, 5);
    check("t1_err", bus.error, 0);

    run(0, edges);
    check("t2_edges", edges, 5);
    check_seq("t2", 4, 32'h8421);
    check("t2_res", bus.resultado, 0);
    check("t2_err", bus.error, 0);

    run(8, edges);
    check("t3a_edges", edges, 2);
    check_seq("t3a", 1, 32'h8);
    check("t3a_res", bus.resultado, 8);
    run(15, edges);
    check_seq("t3b", 4, 32'h8CEF);
    check("t3b_res", bus.resultado, 15);

    @(negedge clk); #1;
    objetivo = 4'd5; bus.inicio = 1'b1;
    @(posedge clk); #1;
    bus.inicio = 1'b0; force_val = 3'b011; force_en = 1'b1;
    wait_listo("t4a");
    check("t4a_err", bus.error, 1);
    check("t4a_res", bus.resultado, 0);
    #1 force_en = 1'b0;
    run(3, edges);
    check("t4b_err", bus.error, 0);
    check("t4b_res", bus.resultado, 3);
    @(negedge clk); #1;
    objetivo = 4'd9; bus.inicio = 1'b1;
    @(posedge clk); #1 bus.inicio = 1'b0;
    @(posedge clk); #1 force_val = 3'b000; force_en = 1'b1;
    wait_listo("t4c");
    check("t4c_err", bus.error, 1);
    check("t4c_res", bus.resultado, 0);
    #1 force_en = 1'b0;

    @(negedge clk); #1;
    objetivo = 4'd5; bus.inicio = 1'b1;
    @(posedge clk); #1 bus.inicio = 1'b0;
    @(posedge clk); #1;
    check("t5_pre_prueba", bus.prueba, 4);
    rst = 1'b1;
    #1;
    check("t5_ocupado", bus.ocupado, 0);
    check("t5_prueba",  bus.prueba,  0);
    check("t5_listo",   bus.listo,   0);
    @(negedge clk);
    rst = 1'b0;
    listo_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.listo) listo_cnt++;
    end
    check("t5_no_listo", listo_cnt, 0);
    run(6, edges);
    check("t5_res", bus.resultado, 6);

    @(negedge clk); #1;
    objetivo = '0;
    bus.inicio = 1'b1;
    for (int a = 0; a < 16; a++) begin
      wait_listo("t6");
      check("t6_res", bus.resultado, a);
      check("t6_err", bus.error, 0);
      #1 objetivo = N'(a + 1);
    end
    bus.inicio = 1'b0;

    repeat (500) begin
      @(negedge clk); #1;
      force_en = 1'b0;
      bus.inicio = ($urandom_range(0, 3) != 0);
      if (!m_busy) objetivo = N'($urandom);
      else if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 4))
          0: force_val = 3'b000;
          1: force_val = 3'b011;
          2: force_val = 3'b101;
          3: force_val = 3'b110;
          default: force_val = 3'b111;
        endcase
        force_en = 1'b1;
      end
    end
    @(negedge clk); #1;
    force_en = 1'b0;
    bus.inicio = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
